// File: rtl/block_mem_ctrl.sv
// Memory-side responder for a 128-bit cache block port: each block request is
// split into four 32-bit beats on a single-port synchronous SRAM after a programmable wait.
module block_mem_ctrl #(
    parameter int ADDR_W   = 28,
    parameter int WAIT_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [127:0]      mem_wdata,
    output logic [127:0]      mem_rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W+1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);
    localparam int WCW = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);

    typedef enum logic [2:0] {IDLE, WAIT, XFER, DRAIN, RESP, COOL} state_t;

    state_t             state;
    logic               op_write;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0][31:0]   wdata_q;
    logic [1:0]         beat;
    logic [1:0]         beat_nx;
    logic [WCW-1:0]     wait_cnt;
    logic [2:0][31:0]   rbuf;

    assign beat_nx = beat + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            beat       <= '0;
            wait_cnt   <= '0;
            rbuf       <= '0;
            mem_rdata  <= '0;
            mem_ready  <= 1'b0;
            busy       <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read | mem_write) begin
                        op_write <= mem_write;
                        addr_q   <= mem_addr;
                        wdata_q  <= mem_wdata;
                        beat     <= '0;
                        wait_cnt <= WCW'(WAIT_CYC);
                        busy     <= 1'b1;
                        // With no wait the first beat goes out straight from the request inputs.
                        if (WAIT_CYC == 0) begin
                            state      <= XFER;
                            sram_en    <= 1'b1;
                            sram_we    <= mem_write;
                            sram_addr  <= {mem_addr, 2'b00};
                            sram_wdata <= mem_wdata[31:0];
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt <= WCW'(1)) begin
                        state      <= XFER;
                        sram_en    <= 1'b1;
                        sram_we    <= op_write;
                        sram_addr  <= {addr_q, 2'b00};
                        sram_wdata <= wdata_q[0];
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                XFER: begin
                    // Read word of the previous beat arrives now; shift it in from the top.
                    if (beat != 2'd0)
                        rbuf <= {sram_rdata, rbuf[2:1]};
                    if (beat == 2'd3) begin
                        state   <= DRAIN;
                        sram_en <= 1'b0;
                        sram_we <= 1'b0;
                    end else begin
                        beat       <= beat_nx;
                        sram_addr  <= {addr_q, beat_nx};
                        sram_wdata <= wdata_q[beat_nx];
                    end
                end
                DRAIN: begin
                    state     <= RESP;
                    mem_ready <= 1'b1;
                    if (!op_write)
                        mem_rdata <= {sram_rdata, rbuf};
                end
                RESP: begin
                    state     <= COOL;
                    mem_ready <= 1'b0;
                end
                COOL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_block_mem_ctrl.sv
// Bench for block_mem_ctrl: two instances (4-cycle and zero wait) driven cache-style,
// checked every cycle against a transaction-offset model plus literal directed expectations.
module tb_block_mem_ctrl;
    localparam int AW = 28;

    typedef struct {
        int          inst;
        int          e;
        logic        we;
        logic [29:0] a;
    } strobe_t;

    logic            clk;
    logic            rst_n;
    logic            rd   [2];
    logic            wr   [2];
    logic [AW-1:0]   ad   [2];
    logic [127:0]    wd   [2];
    logic [127:0]    rdat [2];
    logic            rdy  [2];
    logic            bsy  [2];
    logic            sen  [2];
    logic            swe  [2];
    logic [AW+1:0]   sad  [2];
    logic [31:0]     swd  [2];
    logic [31:0]     srd  [2];

    int n_checks = 0;
    int n_errs   = 0;
    int ecnt     = 0;

    logic [31:0] smem [logic [30:0]];
    logic [31:0] rmem [logic [30:0]];
    strobe_t     slog [$];

    bit             act    [2];
    int             t0     [2];
    logic           wr_l   [2];
    logic [AW-1:0]  ad_l   [2];
    logic [127:0]   wd_l   [2];
    logic [127:0]   exp_rd [2];

    block_mem_ctrl #(.ADDR_W(AW), .WAIT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_addr(ad[0]), .mem_wdata(wd[0]), .mem_rdata(rdat[0]), .mem_ready(rdy[0]),
        .busy(bsy[0]), .sram_en(sen[0]), .sram_we(swe[0]), .sram_addr(sad[0]),
        .sram_wdata(swd[0]), .sram_rdata(srd[0])
    );

    block_mem_ctrl #(.ADDR_W(AW), .WAIT_CYC(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_addr(ad[1]), .mem_wdata(wd[1]), .mem_rdata(rdat[1]), .mem_ready(rdy[1]),
        .busy(bsy[1]), .sram_en(sen[1]), .sram_we(swe[1]), .sram_addr(sad[1]),
        .sram_wdata(swd[1]), .sram_rdata(srd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic logic [30:0] key(input int i, input logic [29:0] a);
        return {i[0], a};
    endfunction

    function automatic logic [31:0] rget(input logic [30:0] k);
        return rmem.exists(k) ? rmem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] sget(input logic [30:0] k);
        return smem.exists(k) ? smem[k] : 32'h0;
    endfunction

    task automatic chk(input string nm, input int i, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errs++;
            $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, i, $time, got, expv);
        end
    endtask

    // SRAM, reference memory and cycle-offset model; compare on the falling edge.
    initial begin : model
        int w, m, k;
        logic [30:0] kk;
        logic eb, ee, er;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; t0[i] = 0; exp_rd[i] = '0; srd[i] <= '0;
            wr_l[i] = 1'b0; ad_l[i] = '0; wd_l[i] = '0;
        end
        forever begin
            @(posedge clk);
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                if (sen[i]) begin
                    kk = key(i, sad[i]);
                    if (swe[i]) smem[kk] = swd[i];
                    else        srd[i] <= sget(kk);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    act[i] = 1'b0; exp_rd[i] = '0;
                end else begin
                    w = wc(i);
                    if (act[i]) begin
                        m = ecnt - t0[i];
                        if (wr_l[i] && m >= w + 1 && m <= w + 4) begin
                            k = m - w - 1;
                            rmem[key(i, {ad_l[i], 2'(k)})] = wd_l[i][32*k +: 32];
                        end
                        if (!wr_l[i] && m == w + 5)
                            for (int j = 0; j < 4; j++)
                                exp_rd[i][32*j +: 32] = rget(key(i, {ad_l[i], 2'(j)}));
                        if (m >= w + 8) act[i] = 1'b0;
                    end
                    if (!act[i] && (rd[i] || wr[i])) begin
                        act[i] = 1'b1; t0[i] = ecnt; wr_l[i] = wr[i];
                        ad_l[i] = ad[i]; wd_l[i] = wd[i];
                    end
                end
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    act[i] = 1'b0; exp_rd[i] = '0;
                end
                w  = wc(i);
                m  = ecnt - t0[i];
                eb = act[i] && m <= w + 6;
                ee = act[i] && m >= w && m <= w + 3;
                er = act[i] && m == w + 5;
                chk("busy", i, 128'(bsy[i]), 128'(eb));
                chk("mem_ready", i, 128'(rdy[i]), 128'(er));
                chk("sram_en", i, 128'(sen[i]), 128'(ee));
                chk("mem_rdata", i, rdat[i], exp_rd[i]);
                if (ee) begin
                    k = m - w;
                    chk("sram_we", i, 128'(swe[i]), 128'(wr_l[i]));
                    chk("sram_addr", i, 128'(sad[i]), 128'({ad_l[i], 2'(k)}));
                    chk("sram_wdata", i, 128'(swd[i]), 128'(wd_l[i][32*k +: 32]));
                end
                if (sen[i]) slog.push_back('{i, ecnt, swe[i], sad[i]});
            end
        end
    end

    // Cache-like requester: hold until ready, optionally through the cool-down cycle.
    task automatic do_req(input int i, input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [127:0] d, input int extra, input bit glitch,
                          output int lat, output int ea);
        int n;
        rd[i] = r; wr[i] = w; ad[i] = a; wd[i] = d;
        ea = ecnt + 1;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
            if (glitch) begin
                ad[i] = AW'($urandom);
                wd[i] = {$urandom, $urandom, $urandom, $urandom};
            end
        end while (!rdy[i] && n < 100);
        lat = n;
        if (!rdy[i]) begin
            n_checks++;
            n_errs++;
            $display("FAIL req_timeout[%0d]: no mem_ready within %0d cycles", i, n);
            rd[i] = 1'b0; wr[i] = 1'b0;
            return;
        end
        @(negedge clk);
        if (extra == 0) begin rd[i] = 1'b0; wr[i] = 1'b0; end
        @(negedge clk);
        rd[i] = 1'b0; wr[i] = 1'b0;
    endtask

    task automatic scan(input int i, output int cnt, output int nwe, output int first_e);
        cnt = 0; nwe = 0; first_e = -1;
        foreach (slog[n]) begin
            if (slog[n].inst == i) begin
                if (cnt == 0) first_e = slog[n].e;
                cnt++;
                if (slog[n].we) nwe++;
            end
        end
    endtask

    task automatic rand_drv(input int i);
        int lat, ea, op;
        logic [AW-1:0] a;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = int'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? '1 : AW'($urandom_range(0, 7));
            do_req(i, op != 1, op == 1 || op == 2, a, {$urandom, $urandom, $urandom, $urandom},
                   int'($urandom_range(0, 1)), $urandom_range(0, 1) == 1, lat, ea);
            chk("rand_latency", i, 128'(lat), 128'(6 + wc(i)));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat, ea, cnt, nwe, first_e;
        logic [127:0] d6;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, 128'(bsy[i]), 128'(0));
            chk("rst_ready", i, 128'(rdy[i]), 128'(0));
            chk("rst_sram_en", i, 128'(sen[i]), 128'(0));
            chk("rst_sram_we", i, 128'(swe[i]), 128'(0));
            chk("rst_sram_addr", i, 128'(sad[i]), 128'(0));
            chk("rst_sram_wdata", i, 128'(swd[i]), 128'(0));
            chk("rst_rdata", i, rdat[i], 128'(0));
        end
        for (int j = 0; j < 4; j++) begin
            smem[key(0, 30'h40 + 30'(j))] = 32'(32'h11111111 * (j + 1));
            rmem[key(0, 30'h40 + 30'(j))] = 32'(32'h11111111 * (j + 1));
            smem[key(1, 30'(j))] = 32'hA0 + 32'(j);
            rmem[key(1, 30'(j))] = 32'hA0 + 32'(j);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Read of block 0x10 with a 4-cycle wait
        slog.delete();
        do_req(0, 1'b1, 1'b0, 28'h10, '0, 0, 1'b0, lat, ea);
        chk("t1_latency", 0, 128'(lat), 128'(10));
        chk("t1_rdata", 0, rdat[0], 128'h44444444_33333333_22222222_11111111);
        scan(0, cnt, nwe, first_e);
        chk("t1_strobes", 0, 128'(cnt), 128'(4));
        chk("t1_first_strobe_cycle", 0, 128'(first_e - ea + 1), 128'(5));
        for (int j = 0; j < 4 && j < slog.size(); j++)
            chk("t1_strobe_addr", j, 128'(slog[j].a), 128'(30'h40 + 30'(j)));

        // Write of block 0x3
        do_req(0, 1'b0, 1'b1, 28'h3, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0, 1'b0, lat, ea);
        chk("t2_latency", 0, 128'(lat), 128'(10));
        chk("t2_word0", 0, 128'(sget(key(0, 30'hC))), 128'(32'hCAFEF00D));
        chk("t2_word3", 0, 128'(sget(key(0, 30'hF))), 128'(32'hDEADBEEF));
        chk("t2_rdata_held", 0, rdat[0], 128'h44444444_33333333_22222222_11111111);

        // Write-back then allocate, request held through the cool-down cycle
        slog.delete();
        do_req(0, 1'b0, 1'b1, 28'h5, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C, 1, 1'b0, lat, ea);
        @(negedge clk);
        do_req(0, 1'b1, 1'b0, 28'h9, '0, 0, 1'b0, lat, ea);
        chk("t3_read_latency", 0, 128'(lat), 128'(10));
        scan(0, cnt, nwe, first_e);
        chk("t3_strobes", 0, 128'(cnt), 128'(8));
        chk("t3_write_strobes", 0, 128'(nwe), 128'(4));
        chk("t3_rdata", 0, rdat[0], 128'(0));

        // Read and write both high: write wins
        slog.delete();
        do_req(0, 1'b1, 1'b1, 28'h1, 128'h13579BDF_2468ACE0_FEDCBA98_76543210, 0, 1'b0, lat, ea);
        scan(0, cnt, nwe, first_e);
        chk("t4_strobes", 0, 128'(cnt), 128'(4));
        chk("t4_write_strobes", 0, 128'(nwe), 128'(4));
        chk("t4_word0", 0, 128'(sget(key(0, 30'h4))), 128'(32'h76543210));

        // Zero-wait instance
        slog.delete();
        do_req(1, 1'b1, 1'b0, 28'h0, '0, 0, 1'b0, lat, ea);
        scan(1, cnt, nwe, first_e);
        chk("t5_latency", 1, 128'(lat), 128'(6));
        chk("t5_first_strobe_cycle", 1, 128'(first_e - ea + 1), 128'(1));
        chk("t5_strobes", 1, 128'(cnt), 128'(4));
        chk("t5_rdata", 1, rdat[1], 128'h000000A3_000000A2_000000A1_000000A0);

        // Reset asserted during beat 2 of a write
        d6 = 128'h66666666_55555555_BBBBBBBB_AAAAAAAA;
        wr[0] = 1'b1; ad[0] = 28'h7; wd[0] = d6;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(sen[0] && sad[0][1:0] == 2'd2) && cnt < 50);
        chk("t6_reached_beat2", 0, 128'(cnt < 50), 128'(1));
        #1 rst_n = 1'b0;
        wr[0] = 1'b0;
        #1;
        chk("t6_rst_sram_en", 0, 128'(sen[0]), 128'(0));
        chk("t6_rst_busy", 0, 128'(bsy[0]), 128'(0));
        chk("t6_rst_sram_we", 0, 128'(swe[0]), 128'(0));
        chk("t6_rst_sram_addr", 0, 128'(sad[0]), 128'(0));
        chk("t6_rst_rdata", 0, rdat[0], 128'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("t6_word0_kept", 0, 128'(sget(key(0, 30'h1C))), 128'(32'hAAAAAAAA));
        chk("t6_word1_kept", 0, 128'(sget(key(0, 30'h1D))), 128'(32'hBBBBBBBB));
        chk("t6_word2_absent", 0, 128'(smem.exists(key(0, 30'h1E))), 128'(0));
        chk("t6_word3_absent", 0, 128'(smem.exists(key(0, 30'h1F))), 128'(0));
        @(negedge clk);
        do_req(0, 1'b1, 1'b0, 28'h7, '0, 0, 1'b0, lat, ea);
        chk("t6_read_latency", 0, 128'(lat), 128'(10));
        chk("t6_read_rdata", 0, rdat[0], 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);

        // Randomized traffic on both instances at once
        fork
            rand_drv(0);
            rand_drv(1);
        join

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
